// File: rtl/maze_move_ctrl.sv
// Maze player movement controller: turns debounced direction pulses into
// wall-map lookups and commits, bumps or wins based on the lookup answer.
module maze_move_ctrl #(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int GOAL_X      = 15,
    parameter int GOAL_Y      = 15,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        BtnU_p,
    input  logic        BtnR_p,
    input  logic        BtnD_p,
    input  logic        BtnL_p,
    output logic        wall_req,
    output logic [7:0]  wall_addr,
    input  logic        wall_ack,
    input  logic        wall_data,
    output logic [3:0]  player_x,
    output logic [3:0]  player_y,
    output logic [15:0] move_count,
    output logic        busy,
    output logic        bump,
    output logic        won
);

    typedef enum logic [1:0] {IDLE, LOOKUP, WON} stateType;

    localparam int          TimerW   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [7:0]  GoalAddr = {4'(GOAL_Y), 4'(GOAL_X)};
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);

    stateType          state, stateNext;
    logic [TimerW-1:0] timer, timerNext;
    logic [3:0]        xNext, yNext;
    logic [15:0]       countNext;
    logic [7:0]        addrNext;
    logic              reqNext, busyNext, bumpNext, wonNext;

    logic [3:0]        targetX, targetY;
    logic              offGrid;
    logic              anyBtn;

    assign anyBtn = BtnU_p | BtnR_p | BtnD_p | BtnL_p;

    // Candidate target for the highest-priority pulse (U > R > D > L).
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        targetX = player_x;
        targetY = player_y;
        offGrid = 1'b0;
        if (BtnU_p) begin
            offGrid = (player_y == 4'd0);
            targetY = player_y - 4'd1;
        end else if (BtnR_p) begin
            offGrid = ({1'b0, player_x} + 5'd1) >= 5'(GRID_W);
            targetX = player_x + 4'd1;
        end else if (BtnD_p) begin
            offGrid = ({1'b0, player_y} + 5'd1) >= 5'(GRID_H);
            targetY = player_y + 4'd1;
        end else if (BtnL_p) begin
            offGrid = (player_x == 4'd0);
            targetX = player_x - 4'd1;
        end
    end

    always_comb begin
        stateNext = state;
        timerNext = timer;
        xNext     = player_x;
        yNext     = player_y;
        countNext = move_count;
        addrNext  = wall_addr;
        reqNext   = wall_req;
        busyNext  = busy;
        bumpNext  = 1'b0;
        wonNext   = won;
        case (state)
            IDLE: begin
                if (anyBtn) begin
                    if (offGrid) begin
                        bumpNext = 1'b1;
                    end else begin
                        addrNext  = {targetY, targetX};
                        reqNext   = 1'b1;
                        busyNext  = 1'b1;
                        timerNext = '0;
                        stateNext = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (wall_ack || timer == TimerLast) begin
                    reqNext   = 1'b0;
                    busyNext  = 1'b0;
                    timerNext = '0;
                    stateNext = IDLE;
                    // A timeout is treated exactly like a wall answer.
                    if (!wall_ack || wall_data) begin
                        bumpNext = 1'b1;
                    end else begin
                        xNext     = wall_addr[3:0];
                        yNext     = wall_addr[7:4];
                        countNext = (move_count == 16'hFFFF) ? move_count : move_count + 16'd1;
                        if (wall_addr == GoalAddr) begin
                            wonNext   = 1'b1;
                            stateNext = WON;
                        end
                    end
                end else begin
                    timerNext = timer + TimerW'(1);
                end
            end
            WON: ;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (Reset) begin
            state      <= IDLE;
            timer      <= '0;
            player_x   <= 4'(START_X);
            player_y   <= 4'(START_Y);
            move_count <= 16'd0;
            wall_addr  <= 8'd0;
            wall_req   <= 1'b0;
            busy       <= 1'b0;
            bump       <= 1'b0;
            won        <= 1'b0;
        end else begin
            state      <= stateNext;
            timer      <= timerNext;
            player_x   <= xNext;
            player_y   <= yNext;
            move_count <= countNext;
            wall_addr  <= addrNext;
            wall_req   <= reqNext;
            busy       <= busyNext;
            bump       <= bumpNext;
            won        <= wonNext;
        end
    end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed-vector bench for maze_move_ctrl with hand-computed expectations.
module tb_maze_move_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        BtnU_p = 1'b0, BtnR_p = 1'b0, BtnD_p = 1'b0, BtnL_p = 1'b0;
    logic        wall_req;
    logic [7:0]  wall_addr;
    logic        wall_ack = 1'b0, wall_data = 1'b0;
    logic [3:0]  player_x, player_y;
    logic [15:0] move_count;
    logic        busy, bump, won;

    int vecCount = 0;
    int missCount = 0;

    localparam logic [3:0] U = 4'b1000, R = 4'b0100, D = 4'b0010, L = 4'b0001;

    maze_move_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .BtnU_p(BtnU_p), .BtnR_p(BtnR_p), .BtnD_p(BtnD_p), .BtnL_p(BtnL_p),
        .wall_req(wall_req), .wall_addr(wall_addr),
        .wall_ack(wall_ack), .wall_data(wall_data),
        .player_x(player_x), .player_y(player_y), .move_count(move_count),
        .busy(busy), .bump(bump), .won(won)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] b);
        {BtnU_p, BtnR_p, BtnD_p, BtnL_p} = b;
        tick();
        {BtnU_p, BtnR_p, BtnD_p, BtnL_p} = 4'b0000;
    endtask

    task automatic ack(input logic data);
        wall_ack  = 1'b1;
        wall_data = data;
        tick();
        wall_ack  = 1'b0;
        wall_data = 1'b0;
    endtask

    task automatic doMove(input logic [3:0] b);
        pulse(b);
        check("mv_req", {31'd0, wall_req}, 32'd1);
        ack(1'b0);
    endtask

    task automatic checkPos(input string tag, input logic [3:0] x, input logic [3:0] y);
        check({tag, "_xy"}, {24'd0, player_y, player_x}, {24'd0, y, x});
    endtask

    initial begin
        // Reset state
        tick(2);
        doReset();
        checkPos("rst", 4'd0, 4'd0);
        check("rst_cnt", {16'd0, move_count}, 32'd0);
        check("rst_flags", {27'd0, wall_req, busy, bump, won, 1'b0}, 32'd0);
        check("rst_addr", {24'd0, wall_addr}, 32'd0);

        // Right move, ack arrives two cycles after the request
        pulse(R);
        check("r_req", {31'd0, wall_req}, 32'd1);
        check("r_busy", {31'd0, busy}, 32'd1);
        check("r_addr", {24'd0, wall_addr}, 32'h01);
        tick();
        check("r_hold", {23'd0, wall_req, wall_addr}, {23'd0, 1'b1, 8'h01});
        ack(1'b0);
        checkPos("r_done", 4'd1, 4'd0);
        check("r_cnt", {16'd0, move_count}, 32'd1);
        check("r_idle", {29'd0, wall_req, busy, bump}, 32'd0);

        // Off-grid moves from (0,0): up and left
        doReset();
        pulse(U);
        check("u_edge", {30'd0, wall_req, bump}, 32'b01);
        checkPos("u_edge", 4'd0, 4'd0);
        tick();
        check("u_bump1", {31'd0, bump}, 32'd0);
        check("u_cnt", {16'd0, move_count}, 32'd0);
        pulse(L);
        check("l_edge", {30'd0, wall_req, bump}, 32'b01);

        // Simultaneous U+R at (3,3): up wins, D during LOOKUP ignored
        doReset();
        doMove(R); doMove(R); doMove(R);
        doMove(D); doMove(D); doMove(D);
        checkPos("at33", 4'd3, 4'd3);
        pulse(U | R);
        check("ur_addr", {24'd0, wall_addr}, 32'h23);
        pulse(D);
        check("d_ign", {23'd0, wall_req, wall_addr}, {23'd0, 1'b1, 8'h23});
        ack(1'b0);
        checkPos("ur_done", 4'd3, 4'd2);
        check("ur_cnt", {16'd0, move_count}, 32'd7);
        tick();
        check("no_queue", {30'd0, wall_req, busy}, 32'd0);

        // Wall hit at (1,0) going down
        doReset();
        doMove(R);
        pulse(D);
        check("wd_addr", {24'd0, wall_addr}, 32'h11);
        ack(1'b1);
        check("wall_bump", {29'd0, wall_req, busy, bump}, 32'b001);
        checkPos("wall", 4'd1, 4'd0);
        tick();
        check("wall_bump1", {31'd0, bump}, 32'd0);
        check("wall_cnt", {16'd0, move_count}, 32'd1);

        // Timeout: no ack for 15 cycles
        pulse(D);
        tick(14);
        check("to_pend", {30'd0, wall_req, bump}, 32'b10);
        tick();
        check("to_abort", {29'd0, wall_req, busy, bump}, 32'b001);
        checkPos("to", 4'd1, 4'd0);
        tick();
        check("to_bump1", {31'd0, bump}, 32'd0);
        ack(1'b0);
        checkPos("stray_ack", 4'd1, 4'd0);
        check("stray_cnt", {16'd0, move_count}, 32'd1);

        // Walk to (14,15), test bottom edge, then win
        doReset();
        for (int i = 0; i < 14; i++) doMove(R);
        for (int i = 0; i < 15; i++) doMove(D);
        checkPos("at1415", 4'd14, 4'd15);
        check("walk_cnt", {16'd0, move_count}, 32'd29);
        pulse(D);
        check("bot_edge", {30'd0, wall_req, bump}, 32'b01);
        doMove(R);
        checkPos("goal", 4'd15, 4'd15);
        check("won", {30'd0, won, busy}, 32'b10);
        check("won_cnt", {16'd0, move_count}, 32'd30);
        pulse(L);
        check("won_frz", {29'd0, wall_req, bump, won}, 32'b001);
        checkPos("won_frz", 4'd15, 4'd15);
        doReset();
        check("won_rst", {31'd0, won}, 32'd0);
        checkPos("won_rst", 4'd0, 4'd0);

        // Reset during LOOKUP, ack follows
        pulse(R);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rl_req", {30'd0, wall_req, busy}, 32'd0);
        ack(1'b0);
        checkPos("rl_ack", 4'd0, 4'd0);
        check("rl_cnt", {16'd0, move_count}, 32'd0);

        // Reset dominates a simultaneous pulse
        Reset = 1'b1;
        BtnR_p = 1'b1;
        tick();
        Reset = 1'b0;
        BtnR_p = 1'b0;
        check("rst_dom", {30'd0, wall_req, bump}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
